apb_slave_mem: RTL
==================

# apb_slave_mem

Word-addressed APB completer with a small register file and programmable wait states. It is the responder end of the APB link driven by the team's Mealy APB master FSM (psel/penable generator), and is the device-under-test target for that master in system benches. It decodes SETUP and ACCESS phases, stretches ACCESS with pready, flags bad addresses with pslverr, and aborts cleanly on master protocol violations.

## Interface
- ADDR_W, 8, byte-address width
- DATA_W, 32, data width; must be 32
- DEPTH, 16, number of 32-bit words; must be ≤ 2^(ADDR_W-2)
- WAIT_CYCLES, 1, wait states inserted before pready, 0..15

- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- psel  in  1  slave select from master
- penable  in  1  access-phase strobe
- pwrite  in  1  1 = write, 0 = read
- paddr  in  ADDR_W  byte address
- pwdata  in  DATA_W  write data
- prdata  out  DATA_W  read data, valid only when pready=1
- pready  out  1  transfer completes this cycle
- pslverr  out  1  error response, valid only when pready=1

## Operation
- FSM states: IDLE, ACCESS.
- IDLE: outputs pready=0, pslverr=0, prdata=0. On psel=1 & penable=0 (SETUP): register paddr, pwrite, pwdata into addr_q/write_q/wdata_q; load wcnt=WAIT_CYCLES; go ACCESS. psel=1 & penable=1 in IDLE (no setup seen) is ignored, stay IDLE.
- ACCESS, psel=1 & penable=1:
  - wcnt≠0: pready=0, wcnt decrements, stay.
  - wcnt=0: pready=1 (combinational, Mealy), complete transfer, next state IDLE.
- ACCESS, psel=0: abort; no write, pready=0, go IDLE.
- ACCESS, psel=1 & penable=0: treated as a new SETUP; recapture address/data, reload wcnt, stay ACCESS; old transfer discarded.
- Decode: index = addr_q[ADDR_W-1:2]. Error if addr_q[1:0]≠0 or index ≥ DEPTH.
- Completion, no error: write → mem[index] ← wdata_q on the completing edge; read → prdata = mem[index]. pslverr=0.
- Completion, error: no memory update; prdata=0; pslverr=1.
- prdata and pslverr are forced to 0 whenever pready=0.
- Back-to-back: a new SETUP may arrive the cycle after completion; IDLE accepts it with no bubble.

## Timing
- Reset (rst=1 at an edge): state IDLE, wcnt=0, all mem words 0, registered fields 0; outputs pready=0, pslverr=0, prdata=0 from the following cycle. Reset mid-transfer drops the transfer with no write.
- SETUP sampled at edge T; first ACCESS cycle T+1; pready=1 in cycle T+1+WAIT_CYCLES. WAIT_CYCLES=0 gives the zero-wait APB transfer (2 cycles total).
- Write takes effect at the edge ending the pready cycle; a read in the next transfer returns it.
- Read data reflects memory at the pready cycle (a write completing in the same edge is not visible).
- wcnt width: 4 bits; no wrap (decrement stops at 0).

## Structure
- apb_pkg: state enum (IDLE, ACCESS), APB_WORD_BYTES=4, localparam for wcnt width.
- Sub-module apb_slave_regfile: DEPTH×32 array, synchronous write port (we, widx, wdata), combinational read port (ridx → rdata), synchronous reset to zero. Top holds FSM, counter, decode, output muxing.

## Test plan
- Reset: rst=1 for 2 cycles, then read 0x00 → pready after 1+WAIT_CYCLES, prdata=0, pslverr=0.
- Zero-wait write/read (WAIT_CYCLES=0): write 0xDEADBEEF to 0x04, read 0x04 → pready in first ACCESS cycle both times, prdata=0xDEADBEEF.
- Wait states (WAIT_CYCLES=2): write 0x12345678 to 0x3C → pready low 2 ACCESS cycles, high on 3rd; back-to-back read of 0x3C with no idle cycle returns 0x12345678.
- Errors: access 0x40 (DEPTH=16) and 0x05 → pready with pslverr=1, prdata=0; subsequent read of 0x04 unchanged.
- Abort: write 0xAAAA5555 to 0x08, drop psel in first wait cycle (WAIT_CYCLES=2) → pready never asserts, later read of 0x08 returns old value.
- Reset mid-transfer: assert rst during wait of write to 0x0C → no write, outputs 0 next cycle, read of 0x0C returns 0.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared types and constants for the APB completer memory block.
package apb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  localparam int APB_WORD_BYTES = 4;
  localparam int WCNT_W         = 4;

  function automatic int idx_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/apb_slave_mem_if.sv
// APB bus bundle between a requester (master) and a completer (slave).
interface apb_slave_mem_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata;
  logic [DATA_W-1:0] prdata;
  logic              pready;
  logic              pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/apb_slave_regfile.sv
// Word array with one synchronous write port and one combinational read port.
module apb_slave_regfile #(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 32,
  parameter int IW     = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_we,
  input  logic [IW-1:0]     i_widx,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [IW-1:0]     i_ridx,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (i_we) begin
      r_mem[i_widx] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_ridx];

endmodule

// File: rtl/apb_slave_mem.sv
// APB completer fronting a small register file, with programmable wait states,
// address-error response and clean abort when the requester drops psel.
module apb_slave_mem
  import apb_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 16,
  parameter int WAIT_CYCLES = 1
) (
  input  logic           i_clk,
  input  logic           i_rst,
  apb_slave_mem_if.slave io_apb
);

  localparam int IDX_W = ADDR_W - 2;
  localparam int IW    = idx_width(DEPTH);
  localparam logic [IDX_W:0]    DEPTH_L = (IDX_W + 1)'(DEPTH);
  localparam logic [WCNT_W-1:0] WAIT_L  = WCNT_W'(WAIT_CYCLES);

  state_t              r_state, w_state_nxt;
  logic [WCNT_W-1:0]   r_wcnt, w_wcnt_nxt;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_write;
  logic [DATA_W-1:0]   r_wdata;

  logic                w_setup, w_capture, w_pready, w_err, w_we;
  logic [IDX_W-1:0]    w_idx;
  logic [DATA_W-1:0]   w_rdata;

  assign w_setup = io_apb.psel & ~io_apb.penable;
  assign w_idx   = r_addr[ADDR_W-1:2];
  assign w_err   = (r_addr[1:0] != 2'b00) || ({1'b0, w_idx} >= DEPTH_L);

  always_comb begin
    w_state_nxt = r_state;
    w_wcnt_nxt  = r_wcnt;
    w_capture   = 1'b0;
    w_pready    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_setup) begin
          w_capture   = 1'b1;
          w_wcnt_nxt  = WAIT_L;
          w_state_nxt = ACCESS;
        end
      end
      ACCESS: begin
        // A fresh SETUP while in ACCESS restarts the transfer; the old one is lost.
        if (!io_apb.psel) begin
          w_state_nxt = IDLE;
        end else if (!io_apb.penable) begin
          w_capture  = 1'b1;
          w_wcnt_nxt = WAIT_L;
        end else if (r_wcnt != '0) begin
          w_wcnt_nxt = r_wcnt - 1'b1;
        end else begin
          w_pready    = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_wcnt  <= '0;
      r_addr  <= '0;
      r_write <= 1'b0;
      r_wdata <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_wcnt  <= w_wcnt_nxt;
      if (w_capture) begin
        r_addr  <= io_apb.paddr;
        r_write <= io_apb.pwrite;
        r_wdata <= io_apb.pwdata;
      end
    end
  end

  assign w_we = w_pready & r_write & ~w_err;

  apb_slave_regfile #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .IW     (IW)
  ) u_regfile (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_we    (w_we),
    .i_widx  (w_idx[IW-1:0]),
    .i_wdata (r_wdata),
    .i_ridx  (w_idx[IW-1:0]),
    .o_rdata (w_rdata)
  );

  assign io_apb.pready  = w_pready;
  assign io_apb.pslverr = w_pready & w_err;
  assign io_apb.prdata  = (w_pready & ~w_err & ~r_write) ? w_rdata : '0;

endmodule
